// File: rtl/skintone_pkg.sv
// Purpose: constants and tag type shared by the skintone mean-Cr blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package skintone_pkg;

    localparam int Y_W      = 8;            // luma sample width
    localparam int CR_FRAC  = 9;            // fractional bits of the mean-Cr result
    localparam int CR_W     = 2 * CR_FRAC;  // (9,9) fixed point result width
    localparam int TAG_ID_W = 3;            // wide enough for up to 8 requesters

    // In-flight tag travelling alongside a sample through the datapath.
    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin arbiter, one-hot grant of first request at/after the pointer.
// Latency: grant is combinational; pointer moves past the winner on the next edge.
// Backpressure: en=0 withholds every grant; a grant is an accept (requests are valid-qualified).
// Ports: clk/rst_n; en; req[N]; grant[N] one-hot; grant_id/grant_vld describe the winner.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_vld
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W:0]   idx;

    // Scan N positions starting at the pointer, wrapping modulo N.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N)) begin
                idx = idx - (ID_W+1)'(N);
            end
            if (en && !grant_vld && req[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
        if (grant_vld) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/meancr_share_ctrl.sv
// Purpose: share one mean-Cr datapath among NUM_REQ requesters, route results back by tag.
// Latency: DP_LATENCY+2 cycles from handshake to res_valid pulse.
// Backpressure: enable=0 or flush=1 stops grants; results have no backpressure (1-cycle pulse).
// Ports: req_valid/req_y/req_ready per requester; dp_y_value(_valid) to and dp_result(_valid) from
//        the datapath; res_data/res_valid/res_id routed result; busy while in flight; tag_err sticky.
module meancr_share_ctrl
    import skintone_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int DP_LATENCY = 3,
    parameter int CNT_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [Y_W-1:0]         dp_y_value,
    output logic                   dp_y_value_valid,
    input  logic [CR_W-1:0]        dp_result,
    input  logic                   dp_result_valid,
    output logic [CR_W-1:0]        res_data,
    output logic [NUM_REQ-1:0]     res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy,
    output logic                   tag_err
);

    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;

    logic [Y_W-1:0]     dp_y_q,      dp_y_d;
    logic               dp_vld_q,    dp_vld_d;
    logic [ID_W-1:0]    dp_id_q,     dp_id_d;
    tag_t               tag_pipe_q [DP_LATENCY];
    tag_t               tag_pipe_d [DP_LATENCY];
    tag_t               tag_out;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [CR_W-1:0]    res_data_q,  res_data_d;
    logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
    logic [ID_W-1:0]    res_id_q,    res_id_d;
    logic               tag_err_q,   tag_err_d;
    logic               unused_tag_bits;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (enable & ~flush),
        .req       (req_valid),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // Grants are valid-qualified, so grant_vld is the handshake.
    always_comb begin
        dp_y_d   = dp_y_q;
        dp_vld_d = grant_vld;
        dp_id_d  = dp_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                dp_y_d  = req_y[i*Y_W +: Y_W];
                dp_id_d = ID_W'(i);
            end
        end
    end

    // Tag follows the registered datapath valid, so the pipe tail lines up with dp_result_valid.
    always_comb begin
        tag_pipe_d[0].vld = dp_vld_q;
        tag_pipe_d[0].id  = TAG_ID_W'(dp_id_q);
        for (int s = 1; s < DP_LATENCY; s++) begin
            tag_pipe_d[s] = tag_pipe_q[s-1];
        end
        tag_out = tag_pipe_q[DP_LATENCY-1];
    end

    assign unused_tag_bits = ^tag_out.id;

    always_comb begin
        res_valid_d = '0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        tag_err_d   = tag_err_q;
        if (tag_out.vld && dp_result_valid) begin
            res_data_d                          = dp_result;
            res_id_d                            = tag_out.id[ID_W-1:0];
            res_valid_d[tag_out.id[ID_W-1:0]]   = 1'b1;
        end else if (tag_out.vld != dp_result_valid) begin
            // Orphan result or unanswered tag: drop it and latch the error.
            tag_err_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({grant_vld, tag_out.vld})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_y_q      <= '0;
            dp_vld_q    <= 1'b0;
            dp_id_q     <= '0;
            for (int s = 0; s < DP_LATENCY; s++) begin
                tag_pipe_q[s] <= '0;
            end
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= '0;
            res_id_q    <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            dp_y_q      <= dp_y_d;
            dp_vld_q    <= dp_vld_d;
            dp_id_q     <= dp_id_d;
            for (int s = 0; s < DP_LATENCY; s++) begin
                tag_pipe_q[s] <= tag_pipe_d[s];
            end
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign dp_y_value       = dp_y_q;
    assign dp_y_value_valid = dp_vld_q;
    assign res_data         = res_data_q;
    assign res_valid        = res_valid_q;
    assign res_id           = res_id_q;
    assign busy             = (cnt_q != '0);
    assign tag_err          = tag_err_q;

endmodule

// File: tb/tb_meancr_share_ctrl.sv
// Purpose: directed bench for meancr_share_ctrl with a 3-cycle behavioural mean-Cr datapath.
// Latency: results expected 5 cycles after each handshake.
// Backpressure: exercises enable/flush gating and reset mid-flight.
module tb_meancr_share_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [3:0]  req_valid;
    logic [31:0] req_y;
    logic [3:0]  req_ready;
    logic [7:0]  dp_y_value;
    logic        dp_y_value_valid;
    logic [17:0] dp_result;
    logic        dp_result_valid;
    logic [17:0] res_data;
    logic [3:0]  res_valid;
    logic [1:0]  res_id;
    logic        busy;
    logic        tag_err;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic        inj_vld;
    logic [2:0]  mv;
    logic [7:0]  my0, my1, my2;

    typedef struct packed {
        logic [3:0]  v;
        logic [1:0]  id;
        logic [17:0] d;
        int          c;
    } res_t;
    res_t res_q[$];

    meancr_share_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_y            (req_y),
        .req_ready        (req_ready),
        .dp_y_value       (dp_y_value),
        .dp_y_value_valid (dp_y_value_valid),
        .dp_result        (dp_result),
        .dp_result_valid  (dp_result_valid),
        .res_data         (res_data),
        .res_valid        (res_valid),
        .res_id           (res_id),
        .busy             (busy),
        .tag_err          (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in mean-Cr: {y+56, y+26} as (9,9); y=100 gives {156,126} = 79998.
    function automatic logic [17:0] mcr(input logic [7:0] y);
        mcr = {9'(y) + 9'd56, 9'(y) + 9'd26};
    endfunction

    // Behavioural datapath, 3 cycles, reset on the same net as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv  <= '0;
            my0 <= '0;
            my1 <= '0;
            my2 <= '0;
        end else begin
            mv  <= {mv[1:0], dp_y_value_valid};
            my0 <= dp_y_value;
            my1 <= my0;
            my2 <= my1;
        end
    end
    assign dp_result_valid = mv[2] | inj_vld;
    assign dp_result       = inj_vld ? 18'h00155 : mcr(my2);

    always @(negedge clk) begin
        if (res_valid !== 4'b0000) begin
            res_q.push_back('{v: res_valid, id: res_id, d: res_data, c: cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        inj_vld   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        res_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        enable = 1'b0; flush = 1'b0; req_valid = '0; req_y = '0; inj_vld = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nvec++; if (dp_y_value !== 8'h00) begin nerr++; $display("FAIL rst_dp_y: got %h expected 00", dp_y_value); end
        nvec++; if (dp_y_value_valid !== 1'b0) begin nerr++; $display("FAIL rst_dp_vld: got %b expected 0", dp_y_value_valid); end
        nvec++; if (res_data !== 18'h0) begin nerr++; $display("FAIL rst_res_data: got %h expected 0", res_data); end
        nvec++; if (res_valid !== 4'b0000) begin nerr++; $display("FAIL rst_res_valid: got %b expected 0000", res_valid); end
        nvec++; if (res_id !== 2'd0) begin nerr++; $display("FAIL rst_res_id: got %0d expected 0", res_id); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b expected 0", busy); end
        nvec++; if (tag_err !== 1'b0) begin nerr++; $display("FAIL rst_tag_err: got %b expected 0", tag_err); end
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL rst_ready_disabled: got %b expected 0000", req_ready); end
        req_valid = '0;
        res_q.delete();
    endtask

    task automatic test_single();
        int g;
        do_reset();
        enable = 1'b1;
        req_y[23:16] = 8'h64;
        req_valid = 4'b0100;
        #1;
        g = cyc;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = '0;
                nvec++; if (dp_y_value !== 8'h64) begin nerr++; $display("FAIL single_dp_y: got %h expected 64", dp_y_value); end
                nvec++; if (dp_y_value_valid !== 1'b1) begin nerr++; $display("FAIL single_dp_vld: got %b expected 1", dp_y_value_valid); end
            end
            if (k == 2) begin
                nvec++; if (dp_y_value_valid !== 1'b0) begin nerr++; $display("FAIL single_dp_vld_drop: got %b expected 0", dp_y_value_valid); end
            end
            nvec++; if (busy !== (k < 5)) begin nerr++; $display("FAIL single_busy_k%0d: got %b expected %b", k, busy, (k < 5)); end
            if (k == 5) begin
                nvec++; if (res_valid !== 4'b0100) begin nerr++; $display("FAIL single_res_valid: got %b expected 0100", res_valid); end
                nvec++; if (res_id !== 2'd2) begin nerr++; $display("FAIL single_res_id: got %0d expected 2", res_id); end
                nvec++; if (res_data !== 18'd79998) begin nerr++; $display("FAIL single_res_data: got %0d expected 79998", res_data); end
            end else begin
                nvec++; if (res_valid !== 4'b0000) begin nerr++; $display("FAIL single_res_quiet_k%0d: got %b expected 0000", k, res_valid); end
            end
        end
        nvec++; if (cyc !== g + 6) begin nerr++; $display("FAIL single_cycle_count: got %0d expected %0d", cyc, g + 6); end
    endtask

    task automatic test_fairness();
        int gc[8];
        logic [3:0] exp_v;
        do_reset();
        enable = 1'b1;
        req_y = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_v = 4'b0001 << (i % 4);
            gc[i] = cyc;
            nvec++; if (req_ready !== exp_v) begin nerr++; $display("FAIL fair_grant_%0d: got %b expected %b", i, req_ready, exp_v); end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (10) @(negedge clk);
        nvec++; if (res_q.size() !== 8) begin nerr++; $display("FAIL fair_res_count: got %0d expected 8", res_q.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < res_q.size()) begin
                exp_v = 4'b0001 << (i % 4);
                nvec++; if (res_q[i].v !== exp_v) begin nerr++; $display("FAIL fair_res_valid_%0d: got %b expected %b", i, res_q[i].v, exp_v); end
                nvec++; if (res_q[i].id !== 2'(i % 4)) begin nerr++; $display("FAIL fair_res_id_%0d: got %0d expected %0d", i, res_q[i].id, i % 4); end
                nvec++; if (res_q[i].d !== mcr(8'(8'h11 * ((i % 4) + 1)))) begin nerr++; $display("FAIL fair_res_data_%0d: got %h expected %h", i, res_q[i].d, mcr(8'(8'h11 * ((i % 4) + 1)))); end
                nvec++; if (res_q[i].c !== gc[i] + 5) begin nerr++; $display("FAIL fair_res_cycle_%0d: got %0d expected %0d", i, res_q[i].c, gc[i] + 5); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int g0;
        do_reset();
        enable = 1'b1;
        req_valid = 4'b0010;
        g0 = cyc;
        for (int i = 0; i < 6; i++) begin
            req_y[15:8] = 8'(10 + i);
            #1;
            nvec++; if (req_ready !== 4'b0010) begin nerr++; $display("FAIL b2b_grant_%0d: got %b expected 0010", i, req_ready); end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (10) @(negedge clk);
        nvec++; if (res_q.size() !== 6) begin nerr++; $display("FAIL b2b_res_count: got %0d expected 6", res_q.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < res_q.size()) begin
                nvec++; if (res_q[i].v !== 4'b0010) begin nerr++; $display("FAIL b2b_res_valid_%0d: got %b expected 0010", i, res_q[i].v); end
                nvec++; if (res_q[i].d !== mcr(8'(10 + i))) begin nerr++; $display("FAIL b2b_res_data_%0d: got %h expected %h", i, res_q[i].d, mcr(8'(10 + i))); end
                nvec++; if (res_q[i].c !== g0 + 5 + i) begin nerr++; $display("FAIL b2b_res_cycle_%0d: got %0d expected %0d", i, res_q[i].c, g0 + 5 + i); end
            end
        end
    endtask

    task automatic test_flush();
        int g3;
        logic [3:0] exp_v;
        do_reset();
        enable = 1'b1;
        req_y = {8'h40, 8'h30, 8'h20, 8'h10};
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_v = 4'b0001 << i;
            nvec++; if (req_ready !== exp_v) begin nerr++; $display("FAIL flush_grant_%0d: got %b expected %b", i, req_ready, exp_v); end
            g3 = cyc;
            @(negedge clk);
        end
        flush = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            nvec++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL flush_ready_k%0d: got %b expected 0000", k, req_ready); end
            nvec++; if (busy !== (k < 5)) begin nerr++; $display("FAIL flush_busy_k%0d: got %b expected %b", k, busy, (k < 5)); end
            @(negedge clk);
        end
        nvec++; if (res_q.size() !== 4) begin nerr++; $display("FAIL flush_res_count: got %0d expected 4", res_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < res_q.size()) begin
                nvec++; if (res_q[i].id !== 2'(i)) begin nerr++; $display("FAIL flush_res_id_%0d: got %0d expected %0d", i, res_q[i].id, i); end
                nvec++; if (res_q[i].d !== mcr(8'(8'h10 * (i + 1)))) begin nerr++; $display("FAIL flush_res_data_%0d: got %h expected %h", i, res_q[i].d, mcr(8'(8'h10 * (i + 1)))); end
            end
        end
        nvec++; if (res_q.size() > 0 && res_q[res_q.size()-1].c !== g3 + 5) begin nerr++; $display("FAIL flush_last_cycle: got %0d expected %0d", res_q[res_q.size()-1].c, g3 + 5); end
        req_valid = '0;
        flush = 1'b0;
    endtask

    task automatic test_error();
        do_reset();
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        nvec++; if (tag_err !== 1'b1) begin nerr++; $display("FAIL err_set: got %b expected 1", tag_err); end
        nvec++; if (res_valid !== 4'b0000) begin nerr++; $display("FAIL err_no_res: got %b expected 0000", res_valid); end
        repeat (4) @(negedge clk);
        nvec++; if (tag_err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b expected 1", tag_err); end
        nvec++; if (res_q.size() !== 0) begin nerr++; $display("FAIL err_res_count: got %0d expected 0", res_q.size()); end
        rst_n = 1'b0;
        #1;
        nvec++; if (tag_err !== 1'b0) begin nerr++; $display("FAIL err_cleared: got %b expected 0", tag_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        enable = 1'b1;
        req_y = {8'h04, 8'h03, 8'h02, 8'h01};
        req_valid = 4'b0111;
        repeat (3) @(negedge clk);
        req_valid = '0;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy_reset: got %b expected 0", busy); end
        nvec++; if (dp_y_value_valid !== 1'b0) begin nerr++; $display("FAIL mid_dp_vld_reset: got %b expected 0", dp_y_value_valid); end
        nvec++; if (dp_y_value !== 8'h00) begin nerr++; $display("FAIL mid_dp_y_reset: got %h expected 00", dp_y_value); end
        nvec++; if (res_valid !== 4'b0000) begin nerr++; $display("FAIL mid_res_valid_reset: got %b expected 0000", res_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        res_q.delete();
        repeat (10) @(negedge clk);
        nvec++; if (res_q.size() !== 0) begin nerr++; $display("FAIL mid_stale_res: got %0d expected 0", res_q.size()); end
        nvec++; if (tag_err !== 1'b0) begin nerr++; $display("FAIL mid_tag_err: got %b expected 0", tag_err); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_flush();
        test_error();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
